// File: rtl/irq_dispatch_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : irq_dispatch_pkg
// Purpose  : Shared types and constants for the interrupt dispatch controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_dispatch_pkg;

    localparam int ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Word offsets decoded from PADDR[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_GAP     = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_TIMEOUT = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_RR_BIT    = 1;
    localparam int STATUS_TMO_BIT = 9;

    function automatic logic [ID_W-1:0] id_after(input logic [ID_W-1:0] id, input int num_lines);
        if (int'(id) >= num_lines - 1)
            return '0;
        return id + ID_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : irq_prio_pick
// Purpose  : Combinational pick of one pending line, fixed or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_pick
    import irq_dispatch_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic [NUM_LINES-1:0] pending,
    input  logic [ID_W-1:0]      ptr,
    input  logic                 rr_mode,
    output logic                 valid,
    output logic [ID_W-1:0]      id
);

    // Scan from the highest offset down so the nearest line at/above start wins.
    always_comb begin
        int start;
        int idx;
        logic [ID_W-1:0] idx_b;
        start = rr_mode ? int'(ptr) : 0;
        valid = |pending;
        id    = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            idx = start + i;
            if (idx >= NUM_LINES)
                idx = idx - NUM_LINES;
            idx_b = idx[ID_W-1:0];
            if (pending[idx_b])
                id = idx_b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_dispatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : irq_dispatch_ctrl
// Purpose  : Dispatches one pending line to the core, returns ack to the
//            service unit, enforces an inter-request gap; APB configured.
//            Optional request timeout: define IRQ_DISPATCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_dispatch_ctrl
    import irq_dispatch_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      pending_i,
    output logic                      core_irq_o,
    output logic [ID_W-1:0]           core_irq_id_o,
    input  logic                      core_irq_ack_i,
    input  logic [ID_W-1:0]           core_irq_ack_id_i,
    output logic                      su_ack_o,
    output logic [ID_W-1:0]           su_ack_id_o
);

    state_t          state, state_nxt;
    logic            ctrl_en, ctrl_rr;
    logic [7:0]      gap_reg, gap_cnt, gap_cnt_nxt;
    logic [ID_W-1:0] rr_ptr, ptr_nxt, last_id, last_id_nxt;
    logic [ID_W-1:0] irq_id_nxt, su_ack_id_nxt, pick_id;
    logic            irq_nxt, su_ack_nxt, pick_valid, ack_match;
    logic            apb_wr, addr_hit;
    logic [1:0]      reg_sel;
    logic            unused_bits;

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    logic [15:0]     tmo_reg, tmo_cnt, tmo_cnt_nxt;
    logic            tmo_sticky, tmo_fire;
`endif

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign apb_wr      = PSEL && PENABLE && PWRITE;
    assign addr_hit    = (PADDR[APB_ADDR_WIDTH-1:4] == '0);
    assign reg_sel     = PADDR[3:2];
    assign ack_match   = core_irq_ack_i && (core_irq_ack_id_i == core_irq_id_o);
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    irq_prio_pick #(
        .NUM_LINES (NUM_LINES)
    ) u_pick (
        .pending (pending_i),
        .ptr     (rr_ptr),
        .rr_mode (ctrl_rr),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    always_comb begin
        state_nxt     = state;
        irq_nxt       = core_irq_o;
        irq_id_nxt    = core_irq_id_o;
        su_ack_nxt    = 1'b0;
        su_ack_id_nxt = su_ack_id_o;
        last_id_nxt   = last_id;
        ptr_nxt       = rr_ptr;
        gap_cnt_nxt   = gap_cnt;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
        tmo_fire      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (ctrl_en && pick_valid) begin
                    state_nxt  = ST_REQ;
                    irq_nxt    = 1'b1;
                    irq_id_nxt = pick_id;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                end
            end
            ST_REQ: begin
                // Only a matching ack or a timeout ends the request; EN/pending do not.
                if (ack_match) begin
                    state_nxt     = ST_ACK;
                    irq_nxt       = 1'b0;
                    su_ack_nxt    = 1'b1;
                    su_ack_id_nxt = core_irq_id_o;
                    last_id_nxt   = core_irq_id_o;
                    ptr_nxt       = id_after(core_irq_id_o, NUM_LINES);
                end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                else if ((tmo_reg != 16'd0) && (tmo_cnt == tmo_reg - 16'd1)) begin
                    state_nxt = ST_IDLE;
                    irq_nxt   = 1'b0;
                    tmo_fire  = 1'b1;
                    ptr_nxt   = id_after(core_irq_id_o, NUM_LINES);
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
`endif
            end
            ST_ACK: begin
                if (gap_reg == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = gap_reg;
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 8'd1)
                    state_nxt = ST_IDLE;
                else
                    gap_cnt_nxt = gap_cnt - 8'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= ST_IDLE;
            core_irq_o    <= 1'b0;
            core_irq_id_o <= '0;
            su_ack_o      <= 1'b0;
            su_ack_id_o   <= '0;
            last_id       <= '0;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            core_irq_o    <= irq_nxt;
            core_irq_id_o <= irq_id_nxt;
            su_ack_o      <= su_ack_nxt;
            su_ack_id_o   <= su_ack_id_nxt;
            last_id       <= last_id_nxt;
            rr_ptr        <= ptr_nxt;
            gap_cnt       <= gap_cnt_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_en <= 1'b0;
            ctrl_rr <= 1'b0;
            gap_reg <= '0;
        end else if (apb_wr && addr_hit) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_en <= PWDATA[CTRL_EN_BIT];
                    ctrl_rr <= PWDATA[CTRL_RR_BIT];
                end
                REG_GAP: gap_reg <= PWDATA[7:0];
                default: ;
            endcase
        end
    end

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    // A timeout in the same cycle as a clearing write keeps the flag set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_reg    <= '0;
            tmo_cnt    <= '0;
            tmo_sticky <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
            if (apb_wr && addr_hit && (reg_sel == REG_TIMEOUT))
                tmo_reg <= PWDATA[15:0];
            if (tmo_fire)
                tmo_sticky <= 1'b1;
            else if (apb_wr && addr_hit && (reg_sel == REG_STATUS) && PWDATA[STATUS_TMO_BIT])
                tmo_sticky <= 1'b0;
        end
    end
`endif

    always_comb begin
        PRDATA = '0;
        if (addr_hit) begin
            case (reg_sel)
                REG_CTRL:   PRDATA[1:0] = {ctrl_rr, ctrl_en};
                REG_GAP:    PRDATA[7:0] = gap_reg;
                REG_STATUS: begin
                    PRDATA[1:0] = state;
                    PRDATA[8:4] = last_id;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                    PRDATA[STATUS_TMO_BIT] = tmo_sticky;
`endif
                end
                default: begin
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                    PRDATA[15:0] = tmo_reg;
`else
                    PRDATA = '0;
`endif
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_irq_dispatch_ctrl
// Purpose  : Directed self-checking bench for irq_dispatch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_dispatch_ctrl;
    import irq_dispatch_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] pending_i;
    logic        core_irq_o;
    logic [4:0]  core_irq_id_o;
    logic        core_irq_ack_i;
    logic [4:0]  core_irq_ack_id_i;
    logic        su_ack_o;
    logic [4:0]  su_ack_id_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    irq_dispatch_ctrl #(
        .APB_ADDR_WIDTH (12),
        .NUM_LINES      (32)
    ) dut (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .PWRITE            (PWRITE),
        .PSEL              (PSEL),
        .PENABLE           (PENABLE),
        .PRDATA            (PRDATA),
        .PREADY            (PREADY),
        .PSLVERR           (PSLVERR),
        .pending_i         (pending_i),
        .core_irq_o        (core_irq_o),
        .core_irq_id_o     (core_irq_id_o),
        .core_irq_ack_i    (core_irq_ack_i),
        .core_irq_ack_id_i (core_irq_ack_id_i),
        .su_ack_o          (su_ack_o),
        .su_ack_id_o       (su_ack_id_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        step();
        PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        step();
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Returns in the cycle after the ack was sampled (su_ack_o expected high).
    task automatic do_ack(input logic [4:0] id);
        core_irq_ack_i = 1'b1; core_irq_ack_id_i = id;
        step();
        core_irq_ack_i = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles);
        int n = 0;
        while (!core_irq_o && n < max_cycles) begin
            step();
            n++;
        end
        if (!core_irq_o)
            check("wait_irq_timeout", {31'd0, core_irq_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;
        logic [4:0]  exp_rr [4];
        exp_rr = '{5'd2, 5'd4, 5'd2, 5'd4};

        HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        pending_i = '0; core_irq_ack_i = 1'b0; core_irq_ack_id_i = '0;
        repeat (3) step();
        check("rst_irq", {31'd0, core_irq_o}, 32'd0);
        check("rst_irq_id", {27'd0, core_irq_id_o}, 32'd0);
        check("rst_su_ack", {31'd0, su_ack_o}, 32'd0);
        check("rst_su_ack_id", {27'd0, su_ack_id_o}, 32'd0);
        check("pready", {31'd0, PREADY}, 32'd1);
        check("pslverr", {31'd0, PSLVERR}, 32'd0);
        HRESETn = 1'b1;
        step();
        apb_read(12'h000, rd); check("rst_ctrl", rd, 32'd0);
        apb_read(12'h008, rd); check("rst_status", rd, 32'd0);

        // Fixed priority: lowest set bit, one-cycle latency each way
        apb_write(12'h000, 32'h1);
        pending_i = 32'h0000_0014;
        step();
        check("fix_irq", {31'd0, core_irq_o}, 32'd1);
        check("fix_id", {27'd0, core_irq_id_o}, 32'd2);
        do_ack(5'd2);
        check("fix_su_ack", {31'd0, su_ack_o}, 32'd1);
        check("fix_su_ack_id", {27'd0, su_ack_id_o}, 32'd2);
        check("fix_irq_drop", {31'd0, core_irq_o}, 32'd0);
        step();
        check("fix_su_ack_1cyc", {31'd0, su_ack_o}, 32'd0);
        check("fix_m2_no_irq", {31'd0, core_irq_o}, 32'd0);
        step();
        check("fix_m3_irq", {31'd0, core_irq_o}, 32'd1);
        check("fix_m3_id", {27'd0, core_irq_id_o}, 32'd2);

        // Asynchronous reset while a request is outstanding
        HRESETn = 1'b0;
        #2;
        check("rstreq_irq", {31'd0, core_irq_o}, 32'd0);
        check("rstreq_id", {27'd0, core_irq_id_o}, 32'd0);
        pending_i = '0;
        step();
        check("rstreq_su_ack", {31'd0, su_ack_o}, 32'd0);
        HRESETn = 1'b1;
        step();

        // Round-robin from pointer 0, then wrap 31 -> 0
        apb_write(12'h000, 32'h3);
        pending_i = 32'h0000_0014;
        for (int k = 0; k < 4; k++) begin
            wait_irq(20);
            check("rr_id", {27'd0, core_irq_id_o}, {27'd0, exp_rr[k]});
            do_ack(exp_rr[k]);
            check("rr_su_ack_id", {27'd0, su_ack_id_o}, {27'd0, exp_rr[k]});
        end
        pending_i = 32'h8000_0001;
        wait_irq(20);
        check("rr_wrap_31", {27'd0, core_irq_id_o}, 32'd31);
        do_ack(5'd31);
        wait_irq(20);
        check("rr_wrap_0", {27'd0, core_irq_id_o}, 32'd0);
        do_ack(5'd0);
        pending_i = '0;
        step(); step();

        // Mismatched ack is ignored
        apb_write(12'h000, 32'h1);
        pending_i = 32'h0000_0020;
        wait_irq(20);
        check("mm_id", {27'd0, core_irq_id_o}, 32'd5);
        apb_read(12'h008, rd); check("mm_status_req", rd, 32'h0000_0001);
        do_ack(5'd3);
        check("mm_irq_held", {31'd0, core_irq_o}, 32'd1);
        check("mm_no_su_ack", {31'd0, su_ack_o}, 32'd0);
        step();
        check("mm_id_held", {27'd0, core_irq_id_o}, 32'd5);
        do_ack(5'd5);
        check("mm_su_ack", {31'd0, su_ack_o}, 32'd1);
        check("mm_su_ack_id", {27'd0, su_ack_id_o}, 32'd5);
        pending_i = '0;

        // GAP=4: next request at M+7; GAP rewritten mid-count is ignored
        apb_write(12'h004, 32'd4);
        pending_i = 32'h0000_0001;
        wait_irq(20);
        check("gap_id", {27'd0, core_irq_id_o}, 32'd0);
        do_ack(5'd0);
        check("gap_su_ack", {31'd0, su_ack_o}, 32'd1);
        apb_write(12'h004, 32'd20);
        repeat (3) step();
        check("gap_m6_no_irq", {31'd0, core_irq_o}, 32'd0);
        step();
        check("gap_m7_irq", {31'd0, core_irq_o}, 32'd1);
        do_ack(5'd0);
        pending_i = '0;
        apb_write(12'h004, 32'd0);

        // EN cleared and pending dropped during REQ do not withdraw the request
        pending_i = 32'h0000_0100;
        wait_irq(40);
        check("en_id", {27'd0, core_irq_id_o}, 32'd8);
        apb_write(12'h000, 32'h0);
        pending_i = '0;
        step();
        check("en_irq_held", {31'd0, core_irq_o}, 32'd1);
        pending_i = 32'h0000_0100;
        do_ack(5'd8);
        check("en_su_ack", {31'd0, su_ack_o}, 32'd1);
        check("en_su_ack_id", {27'd0, su_ack_id_o}, 32'd8);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            seen = seen | core_irq_o;
        end
        check("en_off_no_req", {31'd0, seen}, 32'd0);
        apb_read(12'h008, rd); check("en_status_idle", rd, 32'h0000_0080);

        // Unmapped address neither aliases nor reads back
        apb_write(12'h010, 32'h3);
        apb_read(12'h000, rd); check("unmapped_no_alias", rd, 32'd0);
        apb_read(12'h010, rd); check("unmapped_read", rd, 32'd0);
        pending_i = '0;
        step();

`ifdef IRQ_DISPATCH_TIMEOUT_EN
        apb_write(12'h00C, 32'd10);
        apb_read(12'h00C, rd); check("tmo_reg", rd, 32'd10);
        apb_write(12'h000, 32'h1);
        pending_i = 32'h0000_0080;
        wait_irq(20);
        check("tmo_id", {27'd0, core_irq_id_o}, 32'd7);
        repeat (9) step();
        check("tmo_irq_r9", {31'd0, core_irq_o}, 32'd1);
        step();
        check("tmo_irq_drop", {31'd0, core_irq_o}, 32'd0);
        check("tmo_no_su_ack", {31'd0, su_ack_o}, 32'd0);
        pending_i = '0;
        apb_read(12'h008, rd); check("tmo_sticky", rd, 32'h0000_0280);
        apb_write(12'h008, 32'h0000_0200);
        apb_read(12'h008, rd); check("tmo_sticky_clr", rd, 32'h0000_0080);
`else
        apb_write(12'h00C, 32'h0000_FFFF);
        apb_read(12'h00C, rd); check("tmo_absent_read", rd, 32'd0);
        apb_read(12'h008, rd); check("tmo_absent_status", rd, 32'h0000_0080);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
